// File: rtl/spi_slave_cs_responder.sv
// SPI responder for a CS-framed link: pins are synchronised into i_clk and oversampled.
// Full-duplex bytes per frame, MISO fed from a single preloaded holding register.
`timescale 1ns/1ps
module spi_slave_cs_responder #(
    parameter int SPI_MODE         = 0,
    parameter int MAX_BYTES_PER_CS = 2,
    parameter int SYNC_STAGES      = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_SPI_clk,
    input  logic       i_SPI_CS_n,
    input  logic       i_SPI_MOSI,
    output logic       o_SPI_MISO,
    output logic       o_SPI_MISO_en,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_DV,
    output logic [2:0] o_RX_count,
    output logic       o_TX_underrun,
    output logic       o_overrun,
    output logic       o_frame_done
);
    localparam logic       CPOL  = (SPI_MODE == 2) || (SPI_MODE == 3);
    localparam logic       CPHA  = (SPI_MODE == 1) || (SPI_MODE == 3);
    localparam logic [2:0] MAX_B = 3'(MAX_BYTES_PER_CS);
    localparam int         S     = SYNC_STAGES;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1
    } state_t;

    state_t       r_state;
    logic [S-1:0] r_sck_sync;
    logic [S-1:0] r_cs_sync;
    logic [S-1:0] r_mosi_sync;
    logic         r_sck_q;
    logic         r_cs_q;
    logic [6:0]   r_shift_rx;
    logic [7:0]   r_shift_tx;
    logic [7:0]   r_hold;
    logic         r_hold_full;
    logic [2:0]   r_bit_cnt;

    // CS chain resets to "selected" so a CS already low at reset release never looks like a fall
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sck_sync  <= {S{CPOL}};
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sck_q     <= CPOL;
            r_cs_q      <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[S-2:0], i_SPI_clk};
            r_cs_sync   <= {r_cs_sync[S-2:0], i_SPI_CS_n};
            r_mosi_sync <= {r_mosi_sync[S-2:0], i_SPI_MOSI};
            r_sck_q     <= r_sck_sync[S-1];
            r_cs_q      <= r_cs_sync[S-1];
        end
    end

    logic       w_sck;
    logic       w_cs;
    logic       w_mosi;
    logic       w_edge;
    logic       w_lead;
    logic       w_trail;
    logic       w_sample;
    logic       w_shift;
    logic       w_cs_fall;
    logic       w_cs_rise;
    logic       w_idle;
    logic       w_run;
    logic       w_room;
    logic       w_load;
    logic       w_shift_bit;
    logic       w_tx_acc;
    logic [7:0] w_rx_next;

    assign w_sck       = r_sck_sync[S-1];
    assign w_cs        = r_cs_sync[S-1];
    assign w_mosi      = r_mosi_sync[S-1];
    assign w_edge      = w_sck ^ r_sck_q;
    assign w_lead      = w_edge & (w_sck != CPOL);
    assign w_trail     = w_edge & (w_sck == CPOL);
    assign w_sample    = CPHA ? w_trail : w_lead;
    assign w_shift     = CPHA ? w_lead : w_trail;
    assign w_cs_fall   = r_cs_q & ~w_cs;
    assign w_cs_rise   = ~r_cs_q & w_cs;
    assign w_idle      = (r_state == S_IDLE);
    assign w_run       = (r_state == S_ACTIVE) & ~w_cs_rise;
    assign w_rx_next   = {r_shift_rx, w_mosi};
    assign w_room      = w_idle | (o_RX_count < MAX_B);
    assign w_load      = (w_idle & w_cs_fall & ~CPHA)
                       | (w_run & w_shift & (r_bit_cnt == 3'd0));
    assign w_shift_bit = w_run & w_shift & (r_bit_cnt != 3'd0);
    assign w_tx_acc    = i_TX_DV & ~r_hold_full;

    assign o_TX_Ready  = ~r_hold_full;
    assign o_SPI_MISO  = r_shift_tx[7];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_bit_cnt     <= 3'd0;
            r_shift_rx    <= 7'd0;
            o_RX_Byte     <= 8'h00;
            o_RX_DV       <= 1'b0;
            o_RX_count    <= 3'd0;
            o_overrun     <= 1'b0;
            o_frame_done  <= 1'b0;
            o_SPI_MISO_en <= 1'b0;
        end else begin
            o_RX_DV      <= 1'b0;
            o_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cs_fall) begin
                        r_state       <= S_ACTIVE;
                        r_bit_cnt     <= 3'd0;
                        o_RX_count    <= 3'd0;
                        o_overrun     <= 1'b0;
                        o_SPI_MISO_en <= 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (w_cs_rise) begin
                        r_state       <= S_IDLE;
                        o_frame_done  <= 1'b1;
                        o_SPI_MISO_en <= 1'b0;
                    end else if (w_sample) begin
                        r_shift_rx <= w_rx_next[6:0];
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            if (w_room) begin
                                o_RX_Byte  <= w_rx_next;
                                o_RX_DV    <= 1'b1;
                                o_RX_count <= o_RX_count + 3'd1;
                            end else begin
                                o_overrun <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    o_SPI_MISO_en <= 1'b0;
                end
            endcase
        end
    end

    // A load in the same cycle as a host write sees the old (empty) register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift_tx    <= 8'h00;
            r_hold        <= 8'h00;
            r_hold_full   <= 1'b0;
            o_TX_underrun <= 1'b0;
        end else begin
            o_TX_underrun <= 1'b0;
            if (w_load) begin
                if (w_room && r_hold_full) begin
                    r_shift_tx  <= r_hold;
                    r_hold_full <= 1'b0;
                end else begin
                    r_shift_tx    <= 8'hFF;
                    o_TX_underrun <= w_room;
                end
            end else if (w_shift_bit) begin
                r_shift_tx <= {r_shift_tx[6:0], 1'b0};
            end else if (!w_run) begin
                r_shift_tx <= 8'h00;
            end
            if (w_tx_acc) begin
                r_hold      <= i_TX_Byte;
                r_hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_cs_responder.sv
// Directed bench: one responder per SPI mode, sharing SCK/MOSI,
// each selected by its own chip select.
`timescale 1ns/1ps
module tb_spi_slave_cs_responder;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sck;
    logic       mosi;
    logic       cs_n     [4];
    logic       miso     [4];
    logic       miso_en  [4];
    logic       ready    [4];
    logic       rx_dv    [4];
    logic       und      [4];
    logic       ovr      [4];
    logic       fd       [4];
    logic       tx_dv    [4];
    logic [7:0] tx_byte  [4];
    logic [7:0] rx_byte  [4];
    logic [2:0] rx_cnt   [4];

    logic [7:0] m_tx [8];
    logic [7:0] m_rx [8];

    int dv_cnt [4] = '{0, 0, 0, 0};
    int und_cnt[4] = '{0, 0, 0, 0};
    int fd_cnt [4] = '{0, 0, 0, 0};
    logic [7:0] rx_log [4][16];
    logic [2:0] cnt_log[4][16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_cs_responder #(
            .SPI_MODE(g),
            .MAX_BYTES_PER_CS(2),
            .SYNC_STAGES(2)
        ) u_dut (
            .i_clk(clk),
            .i_rst_n(rst_n),
            .i_SPI_clk(sck),
            .i_SPI_CS_n(cs_n[g]),
            .i_SPI_MOSI(mosi),
            .o_SPI_MISO(miso[g]),
            .o_SPI_MISO_en(miso_en[g]),
            .i_TX_Byte(tx_byte[g]),
            .i_TX_DV(tx_dv[g]),
            .o_TX_Ready(ready[g]),
            .o_RX_Byte(rx_byte[g]),
            .o_RX_DV(rx_dv[g]),
            .o_RX_count(rx_cnt[g]),
            .o_TX_underrun(und[g]),
            .o_overrun(ovr[g]),
            .o_frame_done(fd[g])
        );
    end

    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (rx_dv[d]) begin
                rx_log[d][dv_cnt[d] % 16]  = rx_byte[d];
                cnt_log[d][dv_cnt[d] % 16] = rx_cnt[d];
                dv_cnt[d]++;
            end
            if (und[d]) und_cnt[d]++;
            if (fd[d]) fd_cnt[d]++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tx_load(input int d, input logic [7:0] b);
        int n;
        n = 0;
        while (!ready[d] && n < 400) begin
            @(posedge clk);
            #3;
            n++;
        end
        if (n >= 400) chk("tx_ready_timeout", 32'(ready[d]), 1);
        tx_byte[d] = b;
        tx_dv[d]   = 1'b1;
        @(posedge clk);
        #3;
        tx_dv[d] = 1'b0;
    endtask

    task automatic spi_frame(input int d, input int nbits);
        logic cpol;
        logic cpha;
        int   bi;
        int   bt;
        cpol = (d >= 2);
        cpha = (d % 2 == 1);
        for (int k = 0; k < 8; k++) m_rx[k] = 8'h00;
        sck = cpol;
        #(HALF);
        cs_n[d] = 1'b0;
        if (!cpha) mosi = m_tx[0][7];
        #(HALF);
        for (int i = 0; i < nbits; i++) begin
            bi = i / 8;
            bt = 7 - (i % 8);
            if (cpha) begin
                sck  = ~cpol;
                mosi = m_tx[bi][bt];
                #(HALF);
                m_rx[bi][bt] = miso[d];
                sck = cpol;
                #(HALF);
            end else begin
                m_rx[bi][bt] = miso[d];
                sck = ~cpol;
                #(HALF);
                sck = cpol;
                if (i + 1 < nbits) mosi = m_tx[(i + 1) / 8][7 - ((i + 1) % 8)];
                #(HALF);
            end
        end
        cs_n[d] = 1'b1;
        #(2 * HALF);
    endtask

    int c_dv;
    int c_fd;
    int c_un;

    initial begin
        rst_n = 1'b0;
        sck   = 1'b0;
        mosi  = 1'b0;
        for (int d = 0; d < 4; d++) begin
            cs_n[d]    = 1'b1;
            tx_dv[d]   = 1'b0;
            tx_byte[d] = 8'h00;
        end
        repeat (5) @(posedge clk);
        #3;
        chk("rst_ready", 32'(ready[0]), 1);
        chk("rst_rx_byte", 32'(rx_byte[0]), 'h00);
        chk("rst_rx_dv", 32'(rx_dv[0]), 0);
        chk("rst_rx_cnt", 32'(rx_cnt[0]), 0);
        chk("rst_miso_en", 32'(miso_en[0]), 0);
        chk("rst_miso", 32'(miso[0]), 0);
        chk("rst_ovr", 32'(ovr[0]), 0);
        chk("rst_und", 32'(und[0]), 0);
        chk("rst_fd", 32'(fd[0]), 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #3;

        for (int d = 0; d < 4; d++) begin
            m_tx[0] = 8'h3C;
            m_tx[1] = 8'hC3;
            tx_load(d, 8'hA5);
            c_dv = dv_cnt[d];
            c_fd = fd_cnt[d];
            c_un = und_cnt[d];
            fork
                spi_frame(d, 16);
                tx_load(d, 8'h5A);
            join
            chk($sformatf("m%0d_dv_n", d), dv_cnt[d] - c_dv, 2);
            chk($sformatf("m%0d_rx0", d), 32'(rx_log[d][c_dv % 16]), 'h3C);
            chk($sformatf("m%0d_rx1", d), 32'(rx_log[d][(c_dv + 1) % 16]), 'hC3);
            chk($sformatf("m%0d_cnt0", d), 32'(cnt_log[d][c_dv % 16]), 1);
            chk($sformatf("m%0d_cnt1", d), 32'(cnt_log[d][(c_dv + 1) % 16]), 2);
            chk($sformatf("m%0d_miso0", d), 32'(m_rx[0]), 'hA5);
            chk($sformatf("m%0d_miso1", d), 32'(m_rx[1]), 'h5A);
            chk($sformatf("m%0d_fd_n", d), fd_cnt[d] - c_fd, 1);
            chk($sformatf("m%0d_und_n", d), und_cnt[d] - c_un, 0);
            chk($sformatf("m%0d_en_off", d), 32'(miso_en[d]), 0);
        end

        m_tx[0] = 8'h81;
        c_dv = dv_cnt[1];
        c_un = und_cnt[1];
        spi_frame(1, 8);
        chk("und_miso", 32'(m_rx[0]), 'hFF);
        chk("und_n", und_cnt[1] - c_un, 1);
        chk("und_rx_byte", 32'(rx_byte[1]), 'h81);
        chk("und_dv_n", dv_cnt[1] - c_dv, 1);

        m_tx[0] = 8'hB4;
        c_dv = dv_cnt[0];
        c_fd = fd_cnt[0];
        spi_frame(0, 5);
        chk("part_dv_n", dv_cnt[0] - c_dv, 0);
        chk("part_cnt", 32'(rx_cnt[0]), 0);
        chk("part_fd_n", fd_cnt[0] - c_fd, 1);
        chk("part_en", 32'(miso_en[0]), 0);
        m_tx[0] = 8'h7E;
        c_dv = dv_cnt[0];
        spi_frame(0, 8);
        chk("after_part_dv_n", dv_cnt[0] - c_dv, 1);
        chk("after_part_rx", 32'(rx_byte[0]), 'h7E);
        chk("after_part_cnt", 32'(rx_cnt[0]), 1);

        tx_load(0, 8'h11);
        tx_byte[0] = 8'h99;
        tx_dv[0]   = 1'b1;
        @(posedge clk);
        #3;
        tx_dv[0] = 1'b0;
        m_tx[0] = 8'h01;
        m_tx[1] = 8'h02;
        m_tx[2] = 8'h03;
        c_dv = dv_cnt[0];
        c_un = und_cnt[0];
        fork
            spi_frame(0, 24);
            tx_load(0, 8'h22);
        join
        chk("ovr_dv_n", dv_cnt[0] - c_dv, 2);
        chk("ovr_rx0", 32'(rx_log[0][c_dv % 16]), 'h01);
        chk("ovr_rx1", 32'(rx_log[0][(c_dv + 1) % 16]), 'h02);
        chk("ovr_flag", 32'(ovr[0]), 1);
        chk("ovr_cnt", 32'(rx_cnt[0]), 2);
        chk("ovr_miso0", 32'(m_rx[0]), 'h11);
        chk("ovr_miso1", 32'(m_rx[1]), 'h22);
        chk("ovr_miso2", 32'(m_rx[2]), 'hFF);
        chk("ovr_und_n", und_cnt[0] - c_un, 0);

        m_tx[0] = 8'hC9;
        c_dv = dv_cnt[0];
        fork
            spi_frame(0, 8);
            begin
                #150;
                chk("ovr_clr_fall", 32'(ovr[0]), 0);
                chk("sel_en", 32'(miso_en[0]), 1);
                #50;
                rst_n = 1'b0;
                #5;
                chk("mid_rst_ready", 32'(ready[0]), 1);
                chk("mid_rst_rx_byte", 32'(rx_byte[0]), 'h00);
                chk("mid_rst_en", 32'(miso_en[0]), 0);
                chk("mid_rst_miso", 32'(miso[0]), 0);
                chk("mid_rst_cnt", 32'(rx_cnt[0]), 0);
                #25;
                rst_n = 1'b1;
                #40;
                chk("post_rst_en", 32'(miso_en[0]), 0);
            end
        join
        chk("rst_frame_dv_n", dv_cnt[0] - c_dv, 0);
        m_tx[0] = 8'h55;
        c_dv = dv_cnt[0];
        spi_frame(0, 8);
        chk("post_rst_dv_n", dv_cnt[0] - c_dv, 1);
        chk("post_rst_rx", 32'(rx_byte[0]), 'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
